// File: rtl/iafu_snp_tracker_if.sv
// Bundle between the iAFU snooper / migration engine and the snoop tracker.
// master drives snoops, arm control, drain requests; slave is the tracker.
interface iafu_snp_tracker_if #(
  parameter int MIG_GRP_SIZE = 8,
  parameter int IDX_W        = $clog2(MIG_GRP_SIZE)
);
  logic                    iafu_snp_inv    [4];
  logic [5:0]              iafu_snp_pg_off [4];
  logic [IDX_W-1:0]        iafu_snp_idx    [4];
  logic                    trk_arm_valid;
  logic                    trk_disarm_valid;
  logic [IDX_W-1:0]        trk_arm_idx;
  logic                    drn_req_valid;
  logic                    drn_req_ready;
  logic [IDX_W-1:0]        drn_req_idx;
  logic                    drn_line_valid;
  logic                    drn_line_ready;
  logic [5:0]              drn_line_off;
  logic [IDX_W-1:0]        drn_line_idx;
  logic                    drn_done;
  logic [6:0]              drn_done_cnt;
  logic [MIG_GRP_SIZE-1:0] trk_dirty;
  logic [31:0]             trk_hit_cnt;

  modport master (
    output iafu_snp_inv, iafu_snp_pg_off, iafu_snp_idx,
    output trk_arm_valid, trk_disarm_valid, trk_arm_idx,
    output drn_req_valid, drn_req_idx, drn_line_ready,
    input  drn_req_ready, drn_line_valid, drn_line_off, drn_line_idx,
    input  drn_done, drn_done_cnt, trk_dirty, trk_hit_cnt
  );

  modport slave (
    input  iafu_snp_inv, iafu_snp_pg_off, iafu_snp_idx,
    input  trk_arm_valid, trk_disarm_valid, trk_arm_idx,
    input  drn_req_valid, drn_req_idx, drn_line_ready,
    output drn_req_ready, drn_line_valid, drn_line_off, drn_line_idx,
    output drn_done, drn_done_cnt, trk_dirty, trk_hit_cnt
  );
endinterface

// File: rtl/iafu_snp_tracker.sv
// Per-page 64-line touch bitmaps fed by four snoop ports, plus a drain FSM
// that hands the migration engine every touched line of one page.
module iafu_snp_tracker #(
  parameter int MIG_GRP_SIZE = 8,
  parameter int IDX_W        = $clog2(MIG_GRP_SIZE)
) (
  input  logic              afu_clk,
  input  logic              afu_rstn,
  iafu_snp_tracker_if.slave trk
);
  localparam int NPORT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } drn_state_e;

  function automatic logic [5:0] lowest_set_off(input logic [63:0] bm);
    logic [5:0] off;
    off = 6'd0;
    for (int b = 63; b >= 0; b--) begin
      if (bm[b]) begin
        off = 6'(b);
      end
    end
    return off;
  endfunction

  logic [1:0]              rst_sync_r;
  logic [63:0]             bitmap_r     [MIG_GRP_SIZE];
  logic [63:0]             bitmap_nxt_s [MIG_GRP_SIZE];
  logic [63:0]             set_s        [MIG_GRP_SIZE];
  logic [63:0]             clr_s        [MIG_GRP_SIZE];
  logic [MIG_GRP_SIZE-1:0] en_r;
  logic [MIG_GRP_SIZE-1:0] en_nxt_s;
  logic [MIG_GRP_SIZE-1:0] dirty_r;
  logic [NPORT-1:0]        hit_vec_s;
  logic [2:0]              hit_num_s;
  logic [32:0]             hit_sum_s;
  logic [31:0]             hit_cnt_r;
  logic [63:0]             cur_bm_s;
  logic [63:0]             pick_mask_s;
  logic [5:0]              pick_off_s;
  logic                    pick_take_s;
  drn_state_e              state_r;
  logic                    drn_req_ready_r;
  logic                    drn_line_valid_r;
  logic                    drn_done_r;
  logic [5:0]              drn_line_off_r;
  logic [IDX_W-1:0]        drn_idx_r;
  logic [6:0]              drn_cnt_r;

  // Qualify each snoop port against the armed mask and count the hits
  always_comb begin
    hit_vec_s = '0;
    hit_num_s = 3'd0;
    for (int p = 0; p < NPORT; p++) begin
      if (trk.iafu_snp_inv[p] && (32'(trk.iafu_snp_idx[p]) < MIG_GRP_SIZE)) begin
        hit_vec_s[p] = en_r[trk.iafu_snp_idx[p]];
      end else begin
        hit_vec_s[p] = 1'b0;
      end
      hit_num_s = hit_num_s + {2'b00, hit_vec_s[p]};
    end
    hit_sum_s = {1'b0, hit_cnt_r} + {30'd0, hit_num_s};
  end

  // Lowest touched line of the page under drain
  always_comb begin
    if (32'(drn_idx_r) < MIG_GRP_SIZE) begin
      cur_bm_s = bitmap_r[drn_idx_r];
    end else begin
      cur_bm_s = 64'd0;
    end
    pick_mask_s = cur_bm_s & (~cur_bm_s + 64'd1);
    pick_off_s  = lowest_set_off(cur_bm_s);
    pick_take_s = (state_r == ST_PICK) && (cur_bm_s != 64'd0);
  end

  // Next bitmaps: clears (arm, drain pick) applied first so a same-cycle snoop wins
  always_comb begin
    for (int i = 0; i < MIG_GRP_SIZE; i++) begin
      set_s[i] = 64'd0;
      for (int p = 0; p < NPORT; p++) begin
        if (hit_vec_s[p] && (trk.iafu_snp_idx[p] == IDX_W'(i))) begin
          set_s[i] = set_s[i] | (64'd1 << trk.iafu_snp_pg_off[p]);
        end else begin
          set_s[i] = set_s[i];
        end
      end
      if (trk.trk_arm_valid && (trk.trk_arm_idx == IDX_W'(i))) begin
        clr_s[i] = {64{1'b1}};
      end else if (pick_take_s && (drn_idx_r == IDX_W'(i))) begin
        clr_s[i] = pick_mask_s;
      end else begin
        clr_s[i] = 64'd0;
      end
      bitmap_nxt_s[i] = (bitmap_r[i] & ~clr_s[i]) | set_s[i];
    end
  end

  // Armed mask; disarm takes priority over a simultaneous arm
  always_comb begin
    en_nxt_s = en_r;
    for (int i = 0; i < MIG_GRP_SIZE; i++) begin
      if (trk.trk_arm_idx == IDX_W'(i)) begin
        if (trk.trk_disarm_valid) begin
          en_nxt_s[i] = 1'b0;
        end else if (trk.trk_arm_valid) begin
          en_nxt_s[i] = 1'b1;
        end else begin
          en_nxt_s[i] = en_r[i];
        end
      end else begin
        en_nxt_s[i] = en_r[i];
      end
    end
  end

  // Reset release synchronizer gating drain acceptance
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Tracking state: bitmaps, armed mask, dirty summary, saturating hit count
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      for (int i = 0; i < MIG_GRP_SIZE; i++) begin
        bitmap_r[i] <= 64'd0;
      end
      en_r      <= '0;
      dirty_r   <= '0;
      hit_cnt_r <= 32'd0;
    end else begin
      for (int i = 0; i < MIG_GRP_SIZE; i++) begin
        bitmap_r[i] <= bitmap_nxt_s[i];
        dirty_r[i]  <= |bitmap_nxt_s[i];
      end
      en_r      <= en_nxt_s;
      hit_cnt_r <= hit_sum_s[32] ? 32'hFFFF_FFFF : hit_sum_s[31:0];
    end
  end

  // Drain walk: pick lowest touched line, hand it out, repeat until empty
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      state_r          <= ST_IDLE;
      drn_req_ready_r  <= 1'b0;
      drn_line_valid_r <= 1'b0;
      drn_line_off_r   <= 6'd0;
      drn_idx_r        <= '0;
      drn_cnt_r        <= 7'd0;
      drn_done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          drn_done_r <= 1'b0;
          if (drn_req_ready_r && trk.drn_req_valid) begin
            drn_idx_r       <= trk.drn_req_idx;
            drn_cnt_r       <= 7'd0;
            drn_req_ready_r <= 1'b0;
            state_r         <= ST_PICK;
          end else begin
            drn_req_ready_r <= rst_sync_r[1];
          end
        end
        ST_PICK: begin
          if (pick_take_s) begin
            drn_line_off_r   <= pick_off_s;
            drn_cnt_r        <= drn_cnt_r + 7'd1;
            drn_line_valid_r <= 1'b1;
            state_r          <= ST_EMIT;
          end else begin
            drn_done_r <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_EMIT: begin
          if (trk.drn_line_ready) begin
            drn_line_valid_r <= 1'b0;
            state_r          <= ST_PICK;
          end else begin
            drn_line_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          drn_done_r      <= 1'b0;
          drn_req_ready_r <= rst_sync_r[1];
          state_r         <= ST_IDLE;
        end
        default: begin
          drn_done_r       <= 1'b0;
          drn_line_valid_r <= 1'b0;
          drn_req_ready_r  <= 1'b0;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

  assign trk.drn_req_ready  = drn_req_ready_r;
  assign trk.drn_line_valid = drn_line_valid_r;
  assign trk.drn_line_off   = drn_line_off_r;
  assign trk.drn_line_idx   = drn_idx_r;
  assign trk.drn_done       = drn_done_r;
  assign trk.drn_done_cnt   = drn_cnt_r;
  assign trk.trk_dirty      = dirty_r;
  assign trk.trk_hit_cnt    = hit_cnt_r;
endmodule

// File: tb/tb_iafu_snp_tracker.sv
// Self-checking bench for iafu_snp_tracker: directed scenarios plus random
// snoop traffic compared against a per-page touched-line set model.
module tb_iafu_snp_tracker;
  localparam int G  = 8;
  localparam int IW = 3;

  logic afu_clk  = 1'b0;
  logic afu_rstn = 1'b1;

  iafu_snp_tracker_if #(.MIG_GRP_SIZE(G), .IDX_W(IW)) bus ();

  iafu_snp_tracker #(.MIG_GRP_SIZE(G), .IDX_W(IW)) dut (
    .afu_clk  (afu_clk),
    .afu_rstn (afu_rstn),
    .trk      (bus)
  );

  always #5 afu_clk = ~afu_clk;

  int checks = 0;
  int errors = 0;

  // Reference: which lines of each page were touched, armed pages, hit total
  logic [63:0]  m_bm [G];
  logic [G-1:0] m_en;
  longint       m_hits;

  function automatic logic [G-1:0] model_dirty();
    logic [G-1:0] d;
    for (int i = 0; i < G; i++) d[i] = (m_bm[i] != 64'd0);
    return d;
  endfunction

  task automatic model_lines(input int idx, output logic [5:0] q[$]);
    q = {};
    for (int b = 0; b < 64; b++) if (m_bm[idx][b]) q.push_back(6'(b));
  endtask

  function automatic int first_diff(input logic [5:0] a[$], input logic [5:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < G; i++) m_bm[i] = 64'd0;
    m_en   = '0;
    m_hits = 0;
  endtask

  // One clock: fold this cycle's driven inputs into the model, then advance
  task automatic step();
    logic [G-1:0] en_before;
    en_before = m_en;
    if (bus.trk_arm_valid) m_bm[bus.trk_arm_idx] = 64'd0;
    for (int p = 0; p < 4; p++) begin
      if (bus.iafu_snp_inv[p] && en_before[bus.iafu_snp_idx[p]]) begin
        m_bm[bus.iafu_snp_idx[p]][bus.iafu_snp_pg_off[p]] = 1'b1;
        if (m_hits < 64'd4294967295) m_hits = m_hits + 1;
      end
    end
    if (bus.trk_disarm_valid) m_en[bus.trk_arm_idx] = 1'b0;
    else if (bus.trk_arm_valid) m_en[bus.trk_arm_idx] = 1'b1;
    @(posedge afu_clk);
    #1;
    for (int p = 0; p < 4; p++) bus.iafu_snp_inv[p] = 1'b0;
    bus.trk_arm_valid    = 1'b0;
    bus.trk_disarm_valid = 1'b0;
  endtask

  task automatic arm(input int idx);
    bus.trk_arm_idx   = IW'(idx);
    bus.trk_arm_valid = 1'b1;
    step();
  endtask

  task automatic snoop(input int p, input int idx, input int off);
    bus.iafu_snp_inv[p]    = 1'b1;
    bus.iafu_snp_idx[p]    = IW'(idx);
    bus.iafu_snp_pg_off[p] = 6'(off);
  endtask

  // Request a drain and collect accepted offsets; inj_off>=0 re-snoops in the first PICK cycle
  task automatic run_drain(input int idx, input int rdy_pct, input int inj_off,
                           output logic [5:0] lines[$], output int done_cnt,
                           output int done_cyc, output int bad_idx, output bit timeout);
    int w;
    lines = {}; done_cnt = -1; done_cyc = -1; bad_idx = 0; timeout = 1'b0;
    w = 0;
    while (!bus.drn_req_ready && w < 50) begin step(); w++; end
    bus.drn_req_idx   = IW'(idx);
    bus.drn_req_valid = 1'b1;
    step();
    bus.drn_req_valid = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (bus.drn_done) begin
        done_cnt = int'(bus.drn_done_cnt);
        done_cyc = c;
        break;
      end
      bus.drn_line_ready = ($urandom_range(99) < rdy_pct);
      if (bus.drn_line_valid) begin
        if (bus.drn_line_idx !== IW'(idx)) bad_idx++;
        if (bus.drn_line_ready) lines.push_back(bus.drn_line_off);
      end
      if (c == 1 && inj_off >= 0) snoop(0, idx, inj_off);
      step();
    end
    bus.drn_line_ready = 1'b0;
    if (done_cyc < 0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    #2 afu_rstn = 1'b0;
    repeat (3) @(posedge afu_clk);
    #1;
    checks++; if (bus.drn_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0d want 0", bus.drn_req_ready); end
    checks++; if (bus.drn_line_valid !== 1'b0 || bus.drn_line_off !== 6'd0 || bus.drn_line_idx !== 3'd0) begin
      errors++; $display("FAIL rst_line got v=%0d off=%0d idx=%0d want 0 0 0", bus.drn_line_valid, bus.drn_line_off, bus.drn_line_idx); end
    checks++; if (bus.drn_done !== 1'b0 || bus.drn_done_cnt !== 7'd0) begin
      errors++; $display("FAIL rst_done got done=%0d cnt=%0d want 0 0", bus.drn_done, bus.drn_done_cnt); end
    checks++; if (bus.trk_dirty !== 8'h00 || bus.trk_hit_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_trk got dirty=%0h hits=%0h want 0 0", bus.trk_dirty, bus.trk_hit_cnt); end
    afu_rstn = 1'b1;
    model_reset();
    repeat (4) step();
    checks++; if (bus.drn_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0d want 1", bus.drn_req_ready); end
  endtask

  task automatic test_basic();
    logic [5:0] got[$]; int dcnt, dcyc, bidx, pos; bit tmo;
    arm(2);
    snoop(0, 2, 5);
    snoop(3, 2, 63);
    step();
    checks++; if (bus.trk_dirty !== 8'h04) begin errors++; $display("FAIL basic_dirty got %0h want 04", bus.trk_dirty); end
    checks++; if (bus.trk_hit_cnt !== 32'd2) begin errors++; $display("FAIL basic_hits got %0d want 2", bus.trk_hit_cnt); end
    run_drain(2, 100, -1, got, dcnt, dcyc, bidx, tmo);
    pos = first_diff(got, '{6'd5, 6'd63});
    checks++; if (tmo || pos >= 0) begin errors++; $display("FAIL basic_lines got n=%0d diff_at=%0d timeout=%0d want 5,63", got.size(), pos, tmo); end
    checks++; if (dcnt != 2 || dcyc != 6) begin errors++; $display("FAIL basic_done got cnt=%0d cyc=%0d want 2 6", dcnt, dcyc); end
    checks++; if (bidx != 0) begin errors++; $display("FAIL basic_idx got %0d bad want 0", bidx); end
    m_bm[2] = 64'd0;
    checks++; if (bus.trk_dirty !== model_dirty()) begin errors++; $display("FAIL basic_dirty_after got %0h want %0h", bus.trk_dirty, model_dirty()); end
  endtask

  task automatic test_unarmed();
    snoop(1, 3, 12);
    step();
    checks++; if (bus.trk_dirty !== 8'h00) begin errors++; $display("FAIL unarmed_dirty got %0h want 0", bus.trk_dirty); end
    checks++; if (bus.trk_hit_cnt !== m_hits[31:0]) begin errors++; $display("FAIL unarmed_hits got %0d want %0d", bus.trk_hit_cnt, m_hits); end
  endtask

  task automatic test_resnoop();
    logic [5:0] got[$]; int dcnt, dcyc, bidx, pos; bit tmo;
    arm(1);
    snoop(2, 1, 10);
    step();
    run_drain(1, 100, 10, got, dcnt, dcyc, bidx, tmo);
    pos = first_diff(got, '{6'd10, 6'd10});
    checks++; if (tmo || pos >= 0) begin errors++; $display("FAIL resnoop_lines got n=%0d diff_at=%0d timeout=%0d want 10,10", got.size(), pos, tmo); end
    checks++; if (dcnt != 2 || dcyc != 6) begin errors++; $display("FAIL resnoop_done got cnt=%0d cyc=%0d want 2 6", dcnt, dcyc); end
    m_bm[1] = 64'd0;
    checks++; if (bus.trk_hit_cnt !== m_hits[31:0]) begin errors++; $display("FAIL resnoop_hits got %0d want %0d", bus.trk_hit_cnt, m_hits); end
  endtask

  task automatic test_backpressure();
    int w;
    arm(4);
    snoop(0, 4, 7);
    step();
    w = 0;
    while (!bus.drn_req_ready && w < 50) begin step(); w++; end
    bus.drn_req_idx    = 3'd4;
    bus.drn_req_valid  = 1'b1;
    bus.drn_line_ready = 1'b0;
    step();
    bus.drn_req_valid = 1'b0;
    w = 0;
    while (!bus.drn_line_valid && w < 10) begin step(); w++; end
    for (int k = 0; k < 20; k++) begin
      checks++; if (bus.drn_line_valid !== 1'b1 || bus.drn_line_off !== 6'd7 || bus.drn_line_idx !== 3'd4) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%0d off=%0d idx=%0d want 1 7 4", k, bus.drn_line_valid, bus.drn_line_off, bus.drn_line_idx); end
      step();
    end
    bus.drn_line_ready = 1'b1;
    step();
    bus.drn_line_ready = 1'b0;
    checks++; if (bus.drn_line_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got v=%0d want 0", bus.drn_line_valid); end
    w = 0;
    while (!bus.drn_done && w < 10) begin step(); w++; end
    checks++; if (bus.drn_done !== 1'b1 || bus.drn_done_cnt !== 7'd1) begin
      errors++; $display("FAIL bp_done got done=%0d cnt=%0d want 1 1", bus.drn_done, bus.drn_done_cnt); end
    m_bm[4] = 64'd0;
  endtask

  task automatic test_empty();
    logic [5:0] got[$]; int dcnt, dcyc, bidx; bit tmo;
    run_drain(6, 100, -1, got, dcnt, dcyc, bidx, tmo);
    checks++; if (tmo || dcnt != 0 || dcyc != 2 || got.size() != 0) begin
      errors++; $display("FAIL empty_drain got cnt=%0d cyc=%0d lines=%0d timeout=%0d want 0 2 0", dcnt, dcyc, got.size(), tmo); end
  endtask

  task automatic test_random();
    logic [5:0] got[$]; logic [5:0] exp[$]; int dcnt, dcyc, bidx, pos; bit tmo;
    for (int i = 0; i < G; i++) arm(i);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if ($urandom_range(9) == 0) begin
        bus.trk_arm_idx      = IW'($urandom_range(G - 1));
        bus.trk_arm_valid    = 1'b1;
        bus.trk_disarm_valid = ($urandom_range(3) == 0);
      end else if ($urandom_range(19) == 0) begin
        bus.trk_arm_idx      = IW'($urandom_range(G - 1));
        bus.trk_disarm_valid = 1'b1;
      end
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(2) == 0) snoop(p, $urandom_range(G - 1), $urandom_range(63));
      end
      step();
      checks++; if (bus.trk_dirty !== model_dirty()) begin errors++; $display("FAIL rnd_dirty cyc=%0d got %0h want %0h", cyc, bus.trk_dirty, model_dirty()); end
      checks++; if (bus.trk_hit_cnt !== m_hits[31:0]) begin errors++; $display("FAIL rnd_hits cyc=%0d got %0d want %0d", cyc, bus.trk_hit_cnt, m_hits); end
    end
    for (int i = 0; i < G; i++) begin
      model_lines(i, exp);
      run_drain(i, 60, -1, got, dcnt, dcyc, bidx, tmo);
      pos = first_diff(got, exp);
      checks++; if (tmo || pos >= 0) begin
        errors++; $display("FAIL rnd_lines page=%0d got n=%0d want n=%0d diff_at=%0d timeout=%0d", i, got.size(), exp.size(), pos, tmo); end
      checks++; if (dcnt != (exp.size() % 128) || bidx != 0) begin
        errors++; $display("FAIL rnd_done page=%0d got cnt=%0d bad_idx=%0d want %0d 0", i, dcnt, bidx, exp.size()); end
      m_bm[i] = 64'd0;
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) arm(i);
    force dut.hit_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_r;
    m_hits = 64'hFFFF_FFFE;
    checks++; if (bus.trk_hit_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %0h want fffffffe", bus.trk_hit_cnt); end
    for (int p = 0; p < 4; p++) snoop(p, p, $urandom_range(63));
    step();
    checks++; if (bus.trk_hit_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_four got %0h want ffffffff", bus.trk_hit_cnt); end
    snoop(0, 1, 3);
    snoop(2, 2, 4);
    step();
    checks++; if (bus.trk_hit_cnt !== m_hits[31:0]) begin errors++; $display("FAIL sat_hold got %0h want %0h", bus.trk_hit_cnt, m_hits); end
  endtask

  task automatic test_reset_mid_drain();
    logic [5:0] got[$]; int dcnt, dcyc, bidx, w; bit tmo;
    arm(5);
    snoop(0, 5, 9);
    snoop(1, 5, 20);
    step();
    w = 0;
    while (!bus.drn_req_ready && w < 50) begin step(); w++; end
    bus.drn_req_idx    = 3'd5;
    bus.drn_req_valid  = 1'b1;
    bus.drn_line_ready = 1'b0;
    step();
    bus.drn_req_valid = 1'b0;
    w = 0;
    while (!bus.drn_line_valid && w < 10) begin step(); w++; end
    checks++; if (bus.drn_line_valid !== 1'b1 || bus.drn_line_off !== 6'd9) begin
      errors++; $display("FAIL rstmid_emit got v=%0d off=%0d want 1 9", bus.drn_line_valid, bus.drn_line_off); end
    afu_rstn = 1'b0;
    #1;
    checks++; if (bus.drn_line_valid !== 1'b0 || bus.drn_line_off !== 6'd0 || bus.drn_line_idx !== 3'd0 || bus.drn_req_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_line got v=%0d off=%0d idx=%0d rdy=%0d want 0 0 0 0", bus.drn_line_valid, bus.drn_line_off, bus.drn_line_idx, bus.drn_req_ready); end
    checks++; if (bus.drn_done_cnt !== 7'd0 || bus.trk_dirty !== 8'h00 || bus.trk_hit_cnt !== 32'd0) begin
      errors++; $display("FAIL rstmid_trk got cnt=%0d dirty=%0h hits=%0h want 0 0 0", bus.drn_done_cnt, bus.trk_dirty, bus.trk_hit_cnt); end
    for (int k = 0; k < 3; k++) begin
      @(posedge afu_clk);
      #1;
      checks++; if (bus.drn_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone cyc=%0d got %0d want 0", k, bus.drn_done); end
    end
    afu_rstn = 1'b1;
    model_reset();
    run_drain(5, 100, -1, got, dcnt, dcyc, bidx, tmo);
    checks++; if (tmo || dcnt != 0 || dcyc != 2) begin
      errors++; $display("FAIL rstmid_recover got cnt=%0d cyc=%0d timeout=%0d want 0 2", dcnt, dcyc, tmo); end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      bus.iafu_snp_inv[p]    = 1'b0;
      bus.iafu_snp_pg_off[p] = 6'd0;
      bus.iafu_snp_idx[p]    = 3'd0;
    end
    bus.trk_arm_valid    = 1'b0;
    bus.trk_disarm_valid = 1'b0;
    bus.trk_arm_idx      = 3'd0;
    bus.drn_req_valid    = 1'b0;
    bus.drn_req_idx      = 3'd0;
    bus.drn_line_ready   = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_unarmed();
    test_resnoop();
    test_backpressure();
    test_empty();
    test_random();
    test_saturate();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iafu_snp_tracker.md
# iafu_snp_tracker

Downstream consumer of the iAFU page snooper. Accumulates the per-cycle snoop pulses (four ports: ch0/ch1 read, ch0/ch1 write) into one 64-bit cache-line bitmap per page of the migration group. On request, a drain state machine walks a page's bitmap and hands the migration engine one touched line offset at a time, so those lines are re-copied or invalidated before the page swap commits.

## Interface
Parameters:
- MIG_GRP_SIZE, default 8: pages in the migration group; one bitmap per page.
- IDX_W, default $clog2(MIG_GRP_SIZE): page index width.

Ports:
- afu_clk  in  1  sole clock.
- afu_rstn  in  1  reset; asynchronous, active-low.
- iafu_snp_inv[4]  in  1 each  snoop hit pulse per port.
- iafu_snp_pg_off[4]  in  6 each  64B line offset within the 4KB page.
- iafu_snp_idx[4]  in  IDX_W each  page index of the hit.
- trk_arm_valid  in  1  pulse: clear bitmap of trk_arm_idx and enable tracking on it.
- trk_disarm_valid  in  1  pulse: stop tracking trk_arm_idx; bitmap retained.
- trk_arm_idx  in  IDX_W  page targeted by arm/disarm.
- drn_req_valid  in  1  drain request.
- drn_req_ready  out  1  high only in IDLE.
- drn_req_idx  in  IDX_W  page to drain.
- drn_line_valid  out  1  line offset available.
- drn_line_ready  in  1  consumer accepts the offset.
- drn_line_off  out  6  touched line offset.
- drn_line_idx  out  IDX_W  page of drn_line_off (the latched request index).
- drn_done  out  1  one-cycle pulse when the drain finishes.
- drn_done_cnt  out  7  lines emitted by the last drain; held until the next accept.
- trk_dirty  out  MIG_GRP_SIZE  bit i = OR-reduce of bitmap i (registered state, no extra delay).
- trk_hit_cnt  out  32  total armed snoop hits, saturating.

## Operation
- Armed mask en[MIG_GRP_SIZE]. Snoop port p sets bitmap[idx_p][off_p] when inv_p && en[idx_p]. Unarmed hits are dropped and not counted.
- All four ports are OR-merged in the same cycle. Duplicate page/offset pairs set one bit.
- trk_hit_cnt adds the number of armed hits in the cycle (0–4) and saturates at 0xFFFF_FFFF.
- Arm: bitmap cleared, en set. Disarm: en cleared. Arm and disarm in the same cycle resolve as disarm, with the bitmap still cleared.
- If arm-clear and a snoop set hit the same page in the same cycle, the set wins: the bit is 1 after the edge.
- Drain FSM states:
  - IDLE: drn_req_ready=1. On drn_req_valid, latch idx, zero the count, go to PICK.
  - PICK: if bitmap[idx]==0, go to DONE. Otherwise latch off = lowest set bit, clear that bit, increment the count, go to EMIT.
  - EMIT: drn_line_valid=1, with off and idx held stable. On drn_line_ready, go to PICK.
  - DONE: drn_done=1, drn_done_cnt valid; go to IDLE.
- A snoop to the bit being cleared in PICK wins, so the bit stays set and that line is emitted again later. Lines re-touched during a drain are always re-emitted.
- A drain does not depend on arm state. Arming the draining page mid-drain clears the remaining bits, and the drain then terminates at the next PICK.
- drn_done_cnt is 7 bits: the maximum is 64, or more if lines are re-touched; it wraps modulo 128.

## Timing
- Reset (async assert) values:
  - All bitmaps 0, en 0, FSM IDLE.
  - drn_line_valid 0, drn_line_off 0, drn_line_idx 0.
  - drn_done 0, drn_done_cnt 0, trk_dirty 0, trk_hit_cnt 0.
  - drn_req_ready 0 while afu_rstn low. Deassertion is synchronized internally.
- A snoop at edge t is visible in the bitmap and trk_dirty after edge t+1.
- Drain with N bits set and drn_line_ready held high:
  - Accept at cycle t.
  - Line k (k=1..N) valid in cycle t+2k.
  - drn_done in cycle t+2N+2.
  - N=0 gives drn_done at t+2.
- Backpressure: EMIT holds indefinitely; valid, off and idx do not change until the handshake.
- Reset mid-drain aborts immediately. No drn_done is issued, and drn_line_valid drops asynchronously.

## Test plan
- Arm page 2; pulse port0 off 5 and port3 off 63, both on idx 2 -> trk_dirty=0x04, trk_hit_cnt=2; drain idx 2 with ready high -> offsets 5 then 63, drn_done_cnt=2.
- Snoop idx 3 while unarmed -> bitmap unchanged, trk_dirty=0, trk_hit_cnt unchanged.
- Arm idx 1; set off 10; drain idx 1; in the PICK cycle clearing off 10, snoop off 10 again -> off 10 emitted twice, drn_done_cnt=2.
- Hold drn_line_ready low 20 cycles in EMIT with off 7 -> valid/off/idx stable for 20 cycles; emitted once after ready.
- Preload trk_hit_cnt to 0xFFFF_FFFE; 4 armed hits in one cycle -> 0xFFFF_FFFF.
- Drain an empty page -> drn_done 2 cycles after accept, drn_done_cnt=0. Assert afu_rstn low in EMIT -> all outputs 0 immediately, no drn_done.
